// File: rtl/cmd_arbiter_if.sv
// Bundle for the shared CMD channel: requester-side request/response signals
// plus the command/completion signals exchanged with the CMD block.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface cmd_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]      req;
    logic [6*NUM_REQ-1:0]    req_index;
    logic [32*NUM_REQ-1:0]   req_argument;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      rsp_done;
    logic                    rsp_error;
    logic                    rsp_timeout;
    logic [127:0]            rsp_response;
    logic                    busy;
    logic                    new_command;
    logic [5:0]              cmd_index;
    logic [31:0]             cmd_argument;
    logic                    cmd_complete;
    logic                    cmd_index_error;
    logic [127:0]            response;

    modport master (
        input  req, req_index, req_argument,
        input  cmd_complete, cmd_index_error, response,
        output grant, rsp_done, rsp_error, rsp_timeout, rsp_response, busy,
        output new_command, cmd_index, cmd_argument
    );

    modport slave (
        output req, req_index, req_argument,
        output cmd_complete, cmd_index_error, response,
        input  grant, rsp_done, rsp_error, rsp_timeout, rsp_response, busy,
        input  new_command, cmd_index, cmd_argument
    );
endinterface

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter sharing one CMD command channel between NUM_REQ requesters.
// A granted command holds new_command until cmd_complete or a timeout, returns the
// captured response to its owner, then keeps the channel quiet for GAP_CYCLES cycles.
module cmd_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 8
) (
    input  logic          clk_host,
    input  logic          reset_host,
    cmd_arbiter_if.master bus
);
    localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_d;
    logic [15:0]          tmo_cnt, tmo_cnt_d;
    logic [7:0]           gap_cnt, gap_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 tmo_q, tmo_d;
    logic [127:0]         resp_q, resp_d;
    logic                 busy_q, busy_d;
    logic                 newcmd_q, newcmd_d;
    logic [5:0]           index_q, index_d;
    logic [31:0]          arg_q, arg_d;

    logic                 req_found;
    logic [PTR_W-1:0]     req_sel;
    logic [PTR_W:0]       scan_sum;
    logic [PTR_W:0]       sel_next;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [5:0]           sel_index;
    logic [31:0]          sel_argument;

    // Find the first pending request scanning circularly upward from rr_ptr.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            if (!req_found && bus.req[scan_sum[PTR_W-1:0]]) begin
                req_found = 1'b1;
                req_sel   = scan_sum[PTR_W-1:0];
            end
        end
    end

    // Decode the selected requester into its one-hot grant, index, argument and successor pointer.
    always_comb begin
        sel_onehot   = '0;
        sel_index    = '0;
        sel_argument = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_sel == PTR_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_index     = bus.req_index[k*6 +: 6];
                sel_argument  = bus.req_argument[k*32 +: 32];
            end
        end
        sel_next = {1'b0, req_sel} + (PTR_W + 1)'(1);
        if (sel_next == NUM_REQ_W) begin
            sel_next = '0;
        end
    end

    // Next-state and next-output logic; completion beats timeout when both happen together.
    always_comb begin
        state_d   = state;
        rr_ptr_d  = rr_ptr;
        tmo_cnt_d = tmo_cnt;
        gap_cnt_d = gap_cnt;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = err_q;
        tmo_d     = tmo_q;
        resp_d    = resp_q;
        newcmd_d  = newcmd_q;
        index_d   = index_q;
        arg_d     = arg_q;
        case (state)
            IDLE: begin
                if (req_found) begin
                    grant_d   = sel_onehot;
                    index_d   = sel_index;
                    arg_d     = sel_argument;
                    newcmd_d  = 1'b1;
                    rr_ptr_d  = sel_next[PTR_W-1:0];
                    tmo_cnt_d = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                tmo_cnt_d = tmo_cnt + 16'd1;
                if (bus.cmd_complete) begin
                    resp_d    = bus.response;
                    err_d     = bus.cmd_index_error;
                    tmo_d     = 1'b0;
                    done_d    = grant_q;
                    newcmd_d  = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (tmo_cnt == TMO_LAST) begin
                    resp_d    = '0;
                    err_d     = 1'b0;
                    tmo_d     = 1'b1;
                    done_d    = grant_q;
                    newcmd_d  = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt + 8'd1;
                if (gap_cnt == GAP_LAST) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counters and every output are registered and cleared asynchronously by reset.
    always_ff @(posedge clk_host or negedge reset_host) begin
        if (!reset_host) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            resp_q   <= '0;
            busy_q   <= 1'b0;
            newcmd_q <= 1'b0;
            index_q  <= '0;
            arg_q    <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            tmo_cnt  <= tmo_cnt_d;
            gap_cnt  <= gap_cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            resp_q   <= resp_d;
            busy_q   <= busy_d;
            newcmd_q <= newcmd_d;
            index_q  <= index_d;
            arg_q    <= arg_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.rsp_done     = done_q;
    assign bus.rsp_error    = err_q;
    assign bus.rsp_timeout  = tmo_q;
    assign bus.rsp_response = resp_q;
    assign bus.busy         = busy_q;
    assign bus.new_command  = newcmd_q;
    assign bus.cmd_index    = index_q;
    assign bus.cmd_argument = arg_q;
endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: directed scenarios push the expected completion
// into a queue and a negedge monitor pops and compares on every rsp_done pulse.
module tb_cmd_arbiter;
    localparam int NUM_REQ        = 3;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int GAP_CYCLES     = 8;

    typedef struct {
        logic [NUM_REQ-1:0] done;
        logic               error;
        logic               timeout;
        logic [127:0]       response;
    } rsp_t;

    rsp_t       expected_q[$];
    rsp_t       mon_exp;
    int         vectors     = 0;
    int         miscompares = 0;
    logic       clk_host    = 1'b0;
    logic       reset_host  = 1'b0;

    logic [NUM_REQ-1:0] rr_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [5:0]         rr_index [4] = '{6'd10, 6'd11, 6'd12, 6'd10};

    cmd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    cmd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES)
    ) dut (
        .clk_host   (clk_host),
        .reset_host (reset_host),
        .bus        (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk_host = ~clk_host;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic complete,
                                 input logic index_error, input logic [127:0] resp);
        bus.req             = r;
        bus.cmd_complete    = complete;
        bus.cmd_index_error = index_error;
        bus.response        = resp;
    endtask

    task automatic setRequester(input int i, input logic [5:0] idx, input logic [31:0] arg);
        bus.req_index[i*6 +: 6]     = idx;
        bus.req_argument[i*32 +: 32] = arg;
    endtask

    task automatic pushExpected(input logic [NUM_REQ-1:0] done, input logic error,
                                input logic timeout, input logic [127:0] resp);
        rsp_t e;
        e.done     = done;
        e.error    = error;
        e.timeout  = timeout;
        e.response = resp;
        expected_q.push_back(e);
    endtask

    task automatic waitForCommand();
        int cycles = 0;
        while (!bus.new_command && cycles < 100) begin
            @(negedge clk_host);
            cycles++;
        end
        checkOutput("wait_new_command", 128'(bus.new_command), 128'd1);
    endtask

    task automatic waitIdle();
        int cycles = 0;
        while (bus.busy && cycles < 100) begin
            @(negedge clk_host);
            cycles++;
        end
        checkOutput("wait_idle", 128'(bus.busy), 128'd0);
    endtask

    task automatic doReset();
        reset_host = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk_host);
        reset_host = 1'b1;
        @(negedge clk_host);
    endtask

    // Monitor: every rsp_done pulse must match the oldest queued expectation.
    always @(negedge clk_host) begin
        if (bus.rsp_done !== '0) begin
            if (expected_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_rsp_done actual=%b required=000", bus.rsp_done);
            end else begin
                mon_exp = expected_q.pop_front();
                checkOutput("rsp_done",     128'(bus.rsp_done),    128'(mon_exp.done));
                checkOutput("rsp_error",    128'(bus.rsp_error),   128'(mon_exp.error));
                checkOutput("rsp_timeout",  128'(bus.rsp_timeout), 128'(mon_exp.timeout));
                checkOutput("rsp_response", bus.rsp_response,      mon_exp.response);
                checkOutput("newcmd_at_done", 128'(bus.new_command), 128'd0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed scenarios.
    initial begin
        int cycles;
        bus.req_index    = '0;
        bus.req_argument = '0;
        applyStimulus('0, 1'b0, 1'b0, '0);
        setRequester(0, 6'd17, 32'h0000_0200);
        setRequester(1, 6'd18, 32'h1111_0001);
        setRequester(2, 6'd19, 32'h2222_0002);
        reset_host = 1'b0;
        repeat (3) @(negedge clk_host);

        $display("[TB] reset values");
        checkOutput("reset_grant",        128'(bus.grant),        128'd0);
        checkOutput("reset_new_command",  128'(bus.new_command),  128'd0);
        checkOutput("reset_busy",         128'(bus.busy),         128'd0);
        checkOutput("reset_rsp_done",     128'(bus.rsp_done),     128'd0);
        checkOutput("reset_rsp_response", bus.rsp_response,       128'd0);
        checkOutput("reset_cmd_index",    128'(bus.cmd_index),    128'd0);
        checkOutput("reset_cmd_argument", 128'(bus.cmd_argument), 128'd0);
        reset_host = 1'b1;
        @(negedge clk_host);
        checkOutput("idle_no_req", 128'(bus.busy), 128'd0);

        $display("[TB] single request");
        applyStimulus(3'b001, 1'b0, 1'b0, '0);
        @(negedge clk_host);
        checkOutput("single_grant",    128'(bus.grant),        128'(3'b001));
        checkOutput("single_newcmd",   128'(bus.new_command),  128'd1);
        checkOutput("single_index",    128'(bus.cmd_index),    128'd17);
        checkOutput("single_argument", 128'(bus.cmd_argument), 128'h200);
        checkOutput("single_busy",     128'(bus.busy),         128'd1);
        pushExpected(3'b001, 1'b0, 1'b0, 128'hA5);
        applyStimulus(3'b000, 1'b1, 1'b0, 128'hA5);
        @(negedge clk_host);
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        checkOutput("single_grant_in_gap", 128'(bus.grant), 128'(3'b001));
        waitIdle();
        checkOutput("single_grant_released", 128'(bus.grant), 128'd0);

        $display("[TB] round robin");
        doReset();
        setRequester(0, 6'd10, 32'h0000_00A0);
        setRequester(1, 6'd11, 32'h0000_00A1);
        setRequester(2, 6'd12, 32'h0000_00A2);
        applyStimulus(3'b111, 1'b0, 1'b0, '0);
        @(negedge clk_host);
        for (int n = 0; n < 4; n++) begin
            waitForCommand();
            checkOutput($sformatf("rr_grant_%0d", n), 128'(bus.grant),     128'(rr_order[n]));
            checkOutput($sformatf("rr_index_%0d", n), 128'(bus.cmd_index), 128'(rr_index[n]));
            pushExpected(rr_order[n], 1'b0, 1'b0, 128'(256 + n));
            applyStimulus((n == 3) ? 3'b000 : 3'b111, 1'b1, 1'b0, 128'(256 + n));
            @(negedge clk_host);
            applyStimulus((n == 3) ? 3'b000 : 3'b111, 1'b0, 1'b0, '0);
            if (n < 3) begin
                cycles = 0;
                while (!bus.new_command && cycles < 100) begin
                    cycles++;
                    @(negedge clk_host);
                end
                checkOutput($sformatf("rr_gap_%0d", n), 128'(cycles), 128'(GAP_CYCLES + 1));
            end
        end
        waitIdle();

        $display("[TB] timeout");
        applyStimulus(3'b010, 1'b0, 1'b0, '0);
        @(negedge clk_host);
        waitForCommand();
        checkOutput("tmo_grant", 128'(bus.grant),     128'(3'b010));
        checkOutput("tmo_index", 128'(bus.cmd_index), 128'd11);
        pushExpected(3'b010, 1'b0, 1'b1, 128'd0);
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        cycles = 1;
        @(negedge clk_host);
        while (bus.new_command && cycles < 100) begin
            cycles++;
            @(negedge clk_host);
        end
        checkOutput("tmo_high_cycles", 128'(cycles), 128'(TIMEOUT_CYCLES));
        waitIdle();
        checkOutput("index_kept", 128'(bus.cmd_index), 128'd11);

        $display("[TB] complete and timeout together");
        applyStimulus(3'b100, 1'b0, 1'b0, '0);
        @(negedge clk_host);
        waitForCommand();
        checkOutput("tie_grant", 128'(bus.grant), 128'(3'b100));
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk_host);
        checkOutput("tie_still_high", 128'(bus.new_command), 128'd1);
        pushExpected(3'b100, 1'b1, 1'b0, 128'h5A5A);
        applyStimulus(3'b000, 1'b1, 1'b1, 128'h5A5A);
        @(negedge clk_host);
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        waitIdle();

        $display("[TB] request dropped mid-command");
        applyStimulus(3'b001, 1'b0, 1'b0, '0);
        @(negedge clk_host);
        waitForCommand();
        checkOutput("drop_grant", 128'(bus.grant), 128'(3'b001));
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk_host);
        checkOutput("drop_newcmd_held", 128'(bus.new_command), 128'd1);
        checkOutput("drop_grant_held",  128'(bus.grant),       128'(3'b001));
        pushExpected(3'b001, 1'b0, 1'b0, 128'h77);
        applyStimulus(3'b000, 1'b1, 1'b0, 128'h77);
        @(negedge clk_host);
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        @(negedge clk_host);
        applyStimulus(3'b000, 1'b1, 1'b1, 128'hFF);
        @(negedge clk_host);
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk_host);
        checkOutput("stray_rsp_held",   bus.rsp_response,      128'h77);
        checkOutput("stray_error_held", 128'(bus.rsp_error),   128'd0);
        waitIdle();
        checkOutput("drop_grant_released", 128'(bus.grant), 128'd0);
        repeat (4) @(negedge clk_host);
        checkOutput("drop_no_rearm", 128'(bus.new_command), 128'd0);

        $display("[TB] reset mid-command");
        applyStimulus(3'b010, 1'b0, 1'b0, '0);
        @(negedge clk_host);
        waitForCommand();
        checkOutput("rst_grant_before", 128'(bus.grant), 128'(3'b010));
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk_host);
        reset_host = 1'b0;
        #1;
        checkOutput("rst_async_newcmd",   128'(bus.new_command), 128'd0);
        checkOutput("rst_async_grant",    128'(bus.grant),       128'd0);
        checkOutput("rst_async_busy",     128'(bus.busy),        128'd0);
        checkOutput("rst_async_response", bus.rsp_response,      128'd0);
        @(negedge clk_host);
        applyStimulus(3'b110, 1'b0, 1'b0, '0);
        reset_host = 1'b1;
        @(negedge clk_host);
        checkOutput("rst_regrant_ptr0", 128'(bus.grant),       128'(3'b010));
        checkOutput("rst_regrant_cmd",  128'(bus.new_command), 128'd1);
        pushExpected(3'b010, 1'b0, 1'b0, 128'h99);
        applyStimulus(3'b000, 1'b1, 1'b0, 128'h99);
        @(negedge clk_host);
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        waitIdle();

        repeat (5) @(negedge clk_host);
        checkOutput("scoreboard_empty", 128'(expected_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
